// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA output path (640x480@60 defaults)
// and the coordinate-width helper used by the timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Counter width wide enough to hold the larger of the two raster totals.
    function automatic int coord_width(input int h_total, input int v_total);
        return $clog2((h_total > v_total) ? h_total : v_total);
    endfunction

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_COORD_W = coord_width(DEF_H_TOTAL, DEF_V_TOTAL);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; wrap flags the step
// from TOTAL-1 back to 0 so the next axis can be chained off it.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        wrap  = inc && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: two chained axis counters hold the next position,
// and every output is a registered decode of that position (1 clk latency).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  COORD_W   = coord_width(H_TOTAL, V_TOTAL)
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               en,
    input  logic               sync_clr,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               line_start,
    output logic               frame_start
);

    if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
        V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_param_check
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(COORD_W)) u_h_axis (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .inc     (en),
        .clr     (sync_clr),
        .cnt     (h_cnt),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(COORD_W)) u_v_axis (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .inc     (h_wrap),
        .clr     (sync_clr),
        .cnt     (v_cnt),
        .wrap    (v_wrap)
    );

    // End of frame can only occur on the last pixel of a line.
    assert property (@(posedge clk_in) disable iff (!reset_n)
                     v_wrap |-> (h_cnt == COORD_W'(H_TOTAL - 1)));

    logic [COORD_W-1:0] pix_x_d, pix_x_q;
    logic [COORD_W-1:0] pix_y_d, pix_y_q;
    logic               active_d, active_q;
    logic               hsync_d, hsync_q;
    logic               vsync_d, vsync_q;
    logic               line_start_d, line_start_q;
    logic               frame_start_d, frame_start_q;

    // Strobes default low so they last exactly one clk per presented position.
    always_comb begin
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (sync_clr) begin
            pix_x_d  = '0;
            pix_y_d  = '0;
            active_d = 1'b0;
            hsync_d  = ~HSYNC_POL;
            vsync_d  = ~VSYNC_POL;
        end else if (en) begin
            pix_x_d       = h_cnt;
            pix_y_d       = v_cnt;
            active_d      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
            hsync_d       = (h_cnt >= HS_START && h_cnt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (v_cnt >= VS_START && v_cnt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the VGA output path, clocked by the divided pixel clock from the clock-divider stage.
- Produces hsync/vsync, display-active, current pixel coordinates and line/frame strobes.
- The matrix-result renderer uses these outputs to fetch and colour pixels.
- Default timing is 640x480@60 (800x525 total).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; COORD_W = clog2(max(H_TOTAL, V_TOTAL)), which is 10 at defaults.

Ports:
- clk_in, input, 1, pixel clock (divided clock)
- reset_n, input, 1, asynchronous active-low reset
- en, input, 1, pixel advance enable; all state holds when low
- sync_clr, input, 1, synchronous restart to position (0,0); takes priority over en
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- active, output, 1, high while the presented position is visible
- pix_x, output, COORD_W, presented horizontal position, 0..H_TOTAL-1
- pix_y, output, COORD_W, presented vertical position, 0..V_TOTAL-1
- line_start, output, 1, one-cycle strobe when pix_x==0
- frame_start, output, 1, one-cycle strobe when pix_x==0 and pix_y==0

Behaviour:
- Reset values (reset_n asserted, asynchronous):
  - internal h_cnt = v_cnt = 0
  - pix_x = pix_y = 0, active = 0, line_start = frame_start = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
- Internal counters h_cnt/v_cnt hold the next position to present.
- Every cycle with en=1 and sync_clr=0, all outputs register decodes of (h_cnt, v_cnt), then the counters advance. Latency is 1 clk from counter to outputs, and all outputs are mutually aligned.
- Counter advance:
  - h_cnt increments by 1.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt = V_TOTAL-1 with h wrap, v_cnt wraps to 0.
- Decodes:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL
  - vsync is the same construction on v, using the V_* parameters and VSYNC_POL
  - line_start = (h == 0)
  - frame_start = (h == 0 && v == 0)
- en=0: counters, pix_x, pix_y, active, hsync and vsync hold. line_start and frame_start are driven 0, so each strobe is exactly one clk wide per presented position.
- sync_clr=1, regardless of en:
  - h_cnt = v_cnt = 0, active = 0, strobes = 0, syncs go inactive
  - the next enabled cycle presents (0,0) with frame_start=1
- Reset asserted mid-frame: immediate return to reset values. After release, the first enabled cycle presents (0,0) with both strobes high.
- No combinational path from inputs to outputs. All comparisons are unsigned at COORD_W bits.
- Parameter sums must fit in COORD_W; elaboration error if any parameter is 0.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480 default constants
  - H_TOTAL, V_TOTAL, COORD_W
  - sync polarity constants
- One sub-module, vga_axis_counter:
  - parameters TOTAL and W
  - inputs: inc, clr
  - outputs: cnt, wrap (high when cnt==TOTAL-1 and inc)
  - instantiated twice: h axis (inc=en), and v axis (inc = h wrap).

Test Plan:
- Reset release, en=1 held → first cycle after release: pix=(0,0), active=1, line_start=1, frame_start=1, hsync=vsync=1 (defaults).
- Line sweep → active=1 at pix_x=639, 0 at 640; hsync=0 exactly for pix_x 656..751 (96 cycles); pix_x 799 followed by pix_x=0, pix_y+1, line_start=1.
- Frame sweep → vsync=0 for lines 490..491 (1600 clks); active=0 on lines 480..524; frame_start pulses exactly 420000 clks apart; pix_y 524 wraps to 0.
- en toggling 1,0,1,0 → outputs hold in en=0 cycles; strobes never longer than 1 clk; frame_start spacing 840000 clks.
- sync_clr pulse at pix=(300,200) → next cycle active=0, syncs inactive; next enabled cycle pix=(0,0), frame_start=1; sync_clr with en=0 still clears.
- reset_n asserted mid-line at pix_x=700 (during hsync) → hsync returns to 1 and pix to (0,0) without waiting for a clk edge; normal restart after release.
